// File: rtl/btn_event_gen_pkg.sv
// Shared types for the button event generator: per-channel FSM state encoding.
package btn_event_gen_pkg;

    // Channel states. WAIT_REL blocks a level that was already high at reset
    // or during disable from counting as a new press.
    typedef enum logic [1:0] {
        ST_WAIT_REL = 2'd0,
        ST_IDLE     = 2'd1,
        ST_HELD     = 2'd2,
        ST_REPEAT   = 2'd3
    } btn_state_e;

endpackage

// File: rtl/btn_evt_channel.sv
// One button channel: press / auto-repeat / release FSM with a hold/repeat counter.
// All pulse outputs are registered. evt_next is the unregistered press|rpt value
// that the top uses to build an event bus aligned with these registered pulses.
module btn_evt_channel
    import btn_event_gen_pkg::*;
#(
    parameter int HOLD_CYCLES   = 100000000,
    parameter int REPEAT_CYCLES = 25000000,
    parameter int CNT_W         = 27
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic level,
    output logic press_pulse,
    output logic rpt_pulse,
    output logic rel_pulse,
    output logic long_hold,
    output logic evt_next
);

    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

    btn_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_q, press_d;
    logic             rpt_q, rpt_d;
    logic             rel_q, rel_d;
    logic             long_q, long_d;

    // Next-state, counter and pulse decode for the current sample of level.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it
        // unassigned; a missing default here would infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        press_d = 1'b0;
        rpt_d   = 1'b0;
        rel_d   = 1'b0;

        unique case (state_q)
            ST_WAIT_REL: begin
                if (!level) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (level) begin
                    state_d = ST_HELD;
                    cnt_d   = '0;
                    press_d = 1'b1;
                end
            end
            ST_HELD: begin
                if (!level) begin
                    // Release beats a coincident terminal count.
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    rel_d   = 1'b1;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = ST_REPEAT;
                    cnt_d   = '0;
                    rpt_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_REPEAT: begin
                if (!level) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    rel_d   = 1'b1;
                end else if (cnt_q == REPEAT_LAST) begin
                    cnt_d = '0;
                    rpt_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_WAIT_REL;
        endcase

        // Disable overrides everything, including the release of a held button.
        if (!en) begin
            state_d = ST_WAIT_REL;
            cnt_d   = '0;
            press_d = 1'b0;
            rpt_d   = 1'b0;
            rel_d   = 1'b0;
        end

        long_d = (state_d == ST_REPEAT);
    end

    // State, counter and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            state_q <= ST_WAIT_REL;
            cnt_q   <= '0;
            press_q <= 1'b0;
            rpt_q   <= 1'b0;
            rel_q   <= 1'b0;
            long_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
            rpt_q   <= rpt_d;
            rel_q   <= rel_d;
            long_q  <= long_d;
        end
    end

    assign press_pulse = press_q;
    assign rpt_pulse   = rpt_q;
    assign rel_pulse   = rel_q;
    assign long_hold   = long_q;
    assign evt_next    = press_d | rpt_d;

endmodule

// File: rtl/btn_event_gen.sv
// Button event generator: NUM_BTN independent channels plus a registered
// lowest-index event bus covering press and auto-repeat pulses.
module btn_event_gen
    import btn_event_gen_pkg::*;
#(
    parameter int NUM_BTN       = 4,
    parameter int HOLD_CYCLES   = 100000000,
    parameter int REPEAT_CYCLES = 25000000,
    parameter int CNT_W         = 27,
    parameter int IDX_W         = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] press_pulse,
    output logic [NUM_BTN-1:0] rpt_pulse,
    output logic [NUM_BTN-1:0] rel_pulse,
    output logic [NUM_BTN-1:0] long_hold,
    output logic               evt_valid,
    output logic [IDX_W-1:0]   evt_idx
);

    logic [NUM_BTN-1:0] evt_next;
    logic               evt_valid_q, evt_valid_d;
    logic [IDX_W-1:0]   evt_idx_q, evt_idx_d;

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
        btn_evt_channel #(
            .HOLD_CYCLES  (HOLD_CYCLES),
            .REPEAT_CYCLES(REPEAT_CYCLES),
            .CNT_W        (CNT_W)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .en         (en),
            .level      (btn_level[g]),
            .press_pulse(press_pulse[g]),
            .rpt_pulse  (rpt_pulse[g]),
            .rel_pulse  (rel_pulse[g]),
            .long_hold  (long_hold[g]),
            .evt_next   (evt_next[g])
        );
    end

    // Lowest-index priority encode of the next-cycle press|rpt vector.
    always_comb begin
        evt_valid_d = |evt_next;
        evt_idx_d   = '0;
        for (int i = NUM_BTN - 1; i >= 0; i--) begin
            if (evt_next[i]) evt_idx_d = IDX_W'(i);
        end
    end

    // Register the event bus in step with the channel pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            evt_valid_q <= 1'b0;
            evt_idx_q   <= '0;
        end else begin
            evt_valid_q <= evt_valid_d;
            evt_idx_q   <= evt_idx_d;
        end
    end

    assign evt_valid = evt_valid_q;
    assign evt_idx   = evt_idx_q;

endmodule
